delta_weight_buffer_fetch: RTL and testbench
============================================

Name: delta_weight_buffer_fetch

Overview:
- Per-PU weight buffer front end; the requester side of the weight-manager arbitration handshake.
- On `start` it walks its PU-local weight slice: `INPUT_CHANNEL` channels × `WORDS_PER_IC` words.
- For each word it raises `WB_SRAM_read` with a PU-local byte address and waits for the one-cycle `WB_SRAM_ready` grant. It captures the word from the weight SRAM data bus into a local register file.
- The PU datapath reads the register file through a combinational port, with a per-channel valid bitmap.

Parameters:
- `INPUT_CHANNEL`, 8, input channels held per delta cycle.
- `MAX_WEIGHT_LEN_BYTE`, 8, bytes of weight per input channel; must be a multiple of `DATA_WIDTH/8`.
- `DATA_WIDTH`, 32, width of one fetched word.
- `WORDS_PER_IC`, `MAX_WEIGHT_LEN_BYTE*8/DATA_WIDTH`, derived.
- `TOTAL_WORDS`, `INPUT_CHANNEL*WORDS_PER_IC`, derived.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse: begin filling for a new delta cycle.
- `flush`  in  1  one-cycle pulse: invalidate contents and abort any fill.
- `WB_SRAM_read`  out  1  request to weight manager.
- `WB_SRAM_address`  out  32  PU-local byte address of requested word.
- `WB_SRAM_ready`  in  1  one-cycle grant; data valid this cycle.
- `Weight_SRAM_data`  in  `DATA_WIDTH`  shared weight SRAM read data.
- `rd_index`  in  `clog2(TOTAL_WORDS)`  word index for the PU datapath.
- `rd_data`  out  `DATA_WIDTH`  word at `rd_index`, combinational.
- `ic_valid`  out  `INPUT_CHANNEL`  bit c set once all words of channel c are loaded.
- `busy`  out  1  fill in progress.
- `fill_done`  out  1  one-cycle pulse when last word is captured.

Behaviour:

Reset (`reset`=0, async):
- state=IDLE; `WB_SRAM_read`=0; `WB_SRAM_address`=0; `req_idx`=0.
- `ic_valid`=0; `busy`=0; `fill_done`=0.
- Register file contents are don't-care; no reset is required.

States:
- IDLE → REQ on `start`.
- REQ → DONE on `WB_SRAM_ready` when `req_idx==TOTAL_WORDS-1`; otherwise stay in REQ.
- DONE → IDLE unconditionally. `fill_done`=1 for exactly this cycle.

Outputs by state:
- `WB_SRAM_read`=1 only in REQ. It is registered, so it rises the cycle after `start`.
- `busy`=1 in REQ and DONE.

Addressing:
- `WB_SRAM_address = req_idx * (DATA_WIDTH/8)`, zero-extended to 32 bits. Channel c, word w maps to `req_idx = c*WORDS_PER_IC + w`.
- The address is registered and stable while `WB_SRAM_read`=1.
- It changes only on the edge after a grant.

Handshake:
- `WB_SRAM_read` stays asserted until `WB_SRAM_ready`; there is no timeout.
- On a `ready` cycle:
  - write `Weight_SRAM_data` into `regfile[req_idx]`;
  - increment `req_idx`;
  - update the address on the same edge.
- Back-to-back requests: `read` stays high with the new address. The manager may grant no sooner than its own turnaround; this block accepts `ready` in any REQ cycle.
- `ic_valid[c]` is set on the edge capturing word `c*WORDS_PER_IC+WORDS_PER_IC-1`.
- `WB_SRAM_ready` outside REQ is ignored: no write, no counter change.

Start and flush:
- `start` in IDLE clears `ic_valid` to 0 and `req_idx` to 0 on the same edge.
- `start` while `busy` is ignored.
- `flush` in any state forces IDLE, `read`=0, `ic_valid`=0, `req_idx`=0.
- `flush` and `ready` in the same cycle: flush wins and the data is not written.
- `flush` and `start` in the same cycle: flush wins and no fill starts.

Read port:
- `rd_data = regfile[rd_index]`, purely combinational.
- A same-cycle write to the same index returns the old value; the new value appears next cycle.
- `rd_index >= TOTAL_WORDS` returns 0.

Reset mid-fill:
- Immediately deasserts `WB_SRAM_read` (async).
- The manager-side FSM is reset by the same system reset, so no grant is left outstanding.

Test Plan:
- Nominal fill (defaults, 16 words): `start`, then grant each request 3 cycles after `read` with data=`0xA000_0000+idx`.
  - Required: addresses 0,4,…,60 in order.
  - `ic_valid` rises bit by bit after words 1,3,…,15.
  - `fill_done` pulses once, one cycle after grant 15.
  - `rd_index`=9 returns `0xA000_0009`.
- Back-to-back grants (`ready` every cycle): all 16 words captured in 16 consecutive cycles.
  - Address advances each edge.
  - `read` never drops until DONE.
- Flush mid-fill: flush after 5 grants (in the same cycle as the 6th `ready`).
  - Required: word 5 is not written.
  - `ic_valid` goes from `0x03` to 0; `read`=0 next cycle.
  - A subsequent `start` restarts at address 0.
- Spurious/ignored inputs: `ready` pulsed in IDLE, and `start` pulsed while busy at `req_idx`=7.
  - Required: no regfile write, no counter change.
  - The fill continues from 7 to completion.
- Async reset: `reset`=0 for 2 cycles mid-REQ, asserted between clock edges.
  - Required: `read`, `busy` and `ic_valid` drop before the next edge.
  - After release the block sits in IDLE until `start`.

Source files
------------

// File: rtl/delta_weight_buffer_fetch_if.sv
// Weight-manager arbitration handshake: requester drives read/address,
// manager answers with a one-cycle ready and the shared SRAM data word.
interface delta_weight_buffer_fetch_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  WB_SRAM_read;
   logic [31:0]           WB_SRAM_address;
   logic                  WB_SRAM_ready;
   logic [DATA_WIDTH-1:0] Weight_SRAM_data;

   modport master (
      output WB_SRAM_read,
      output WB_SRAM_address,
      input  WB_SRAM_ready,
      input  Weight_SRAM_data
   );

   modport slave (
      input  WB_SRAM_read,
      input  WB_SRAM_address,
      output WB_SRAM_ready,
      output Weight_SRAM_data
   );
endinterface

// File: rtl/delta_weight_buffer_fetch.sv
// Per-PU weight buffer front end. Fetches the PU-local weight slice word by
// word through the weight-manager handshake into a local register file that
// the PU datapath reads combinationally.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; buffer contents held, ready ignored
//   REQ   | read asserted for word req_idx; a ready grant captures it
//   DONE  | last word captured; fill_done pulses, back to IDLE next edge
module delta_weight_buffer_fetch #(
   parameter int INPUT_CHANNEL       = 8,
   parameter int MAX_WEIGHT_LEN_BYTE = 8,
   parameter int DATA_WIDTH          = 32,
   parameter int WORDS_PER_IC        = MAX_WEIGHT_LEN_BYTE * 8 / DATA_WIDTH,
   parameter int TOTAL_WORDS         = INPUT_CHANNEL * WORDS_PER_IC,
   parameter int IDX_W               = (TOTAL_WORDS > 1) ? $clog2(TOTAL_WORDS) : 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      flush,
   delta_weight_buffer_fetch_if.master wb,
   input  logic [IDX_W-1:0]          rd_index,
   output logic [DATA_WIDTH-1:0]     rd_data,
   output logic [INPUT_CHANNEL-1:0]  ic_valid,
   output logic                      busy,
   output logic                      fill_done
);

   localparam logic [31:0] BYTES_PER_WORD = 32'(DATA_WIDTH / 8);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TOTAL_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                   state, state_next;
   logic [IDX_W-1:0]         req_idx, idx_next;
   logic [INPUT_CHANNEL-1:0] ic_valid_next;
   logic [31:0]              address;
   logic                     we;

   logic [DATA_WIDTH-1:0]    regfile [TOTAL_WORDS];

   // State, word counter, channel-valid bitmap and registered address.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         req_idx  <= '0;
         ic_valid <= '0;
         address  <= '0;
      end else begin
         state    <= state_next;
         req_idx  <= idx_next;
         ic_valid <= ic_valid_next;
         address  <= 32'(idx_next) * BYTES_PER_WORD;
      end
   end

   // Next-state logic; flush overrides everything, including a same-cycle grant.
   always_comb begin
      state_next    = state;
      idx_next      = req_idx;
      ic_valid_next = ic_valid;
      we            = 1'b0;
      if (flush) begin
         state_next    = IDLE;
         idx_next      = '0;
         ic_valid_next = '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state_next    = REQ;
                  idx_next      = '0;
                  ic_valid_next = '0;
               end
            end
            REQ: begin
               if (wb.WB_SRAM_ready) begin
                  we       = 1'b1;
                  idx_next = req_idx + IDX_W'(1);
                  for (int c = 0; c < INPUT_CHANNEL; c++) begin
                     if (req_idx == IDX_W'(c * WORDS_PER_IC + WORDS_PER_IC - 1))
                        ic_valid_next[c] = 1'b1;
                  end
                  if (req_idx == LAST_IDX)
                     state_next = DONE;
               end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Register file capture on a granted request; contents need no reset.
   always_ff @(posedge clock) begin
      if (we)
         regfile[req_idx] <= wb.Weight_SRAM_data;
   end

   assign wb.WB_SRAM_read    = (state == REQ);
   assign wb.WB_SRAM_address = address;
   assign busy               = (state != IDLE);
   assign fill_done          = (state == DONE);
   assign rd_data            = (32'(rd_index) < 32'(TOTAL_WORDS)) ? regfile[rd_index] : '0;

endmodule

// File: tb/tb_delta_weight_buffer_fetch.sv
// Directed bench for delta_weight_buffer_fetch: nominal fill, back-to-back
// grants, flush mid-fill, ignored inputs and async reset mid-fill.
module tb_delta_weight_buffer_fetch;

   logic        clock;
   logic        reset;
   logic        start;
   logic        flush;
   logic [3:0]  rd_index;
   logic [31:0] rd_data;
   logic [7:0]  ic_valid;
   logic        busy;
   logic        fill_done;

   int errors = 0;
   int checks = 0;

   delta_weight_buffer_fetch_if #(.DATA_WIDTH(32)) wb_if ();

   delta_weight_buffer_fetch dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .flush     (flush),
      .wb        (wb_if),
      .rd_index  (rd_index),
      .rd_data   (rd_data),
      .ic_valid  (ic_valid),
      .busy      (busy),
      .fill_done (fill_done)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset    = 1'b0;
      start    = 1'b0;
      flush    = 1'b0;
      rd_index = '0;
      wb_if.WB_SRAM_ready    = 1'b0;
      wb_if.Weight_SRAM_data = '0;

      // Reset state
      @(negedge clock);
      chk("rst_read", wb_if.WB_SRAM_read, 0);
      chk("rst_addr", wb_if.WB_SRAM_address, 0);
      chk("rst_busy", busy, 0);
      chk("rst_icv", ic_valid, 0);
      chk("rst_done", fill_done, 0);
      reset = 1'b1;

      // Nominal fill: grant on the third cycle of each request
      @(negedge clock);
      start = 1'b1;
      for (int i = 0; i < 16; i++) begin
         for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            start = 1'b0;
            chk("nom_read", wb_if.WB_SRAM_read, 1);
            chk("nom_addr", wb_if.WB_SRAM_address, 32'(i * 4));
            if (k == 0) begin
               chk("nom_icv", ic_valid, 32'((1 << (i / 2)) - 1));
               chk("nom_nodone", fill_done, 0);
            end
            wb_if.WB_SRAM_ready    = (k == 2);
            wb_if.Weight_SRAM_data = 32'hA000_0000 + 32'(i);
         end
      end
      @(negedge clock);
      wb_if.WB_SRAM_ready = 1'b0;
      chk("nom_done", fill_done, 1);
      chk("nom_busy_done", busy, 1);
      chk("nom_read_done", wb_if.WB_SRAM_read, 0);
      chk("nom_icv_full", ic_valid, 32'hFF);
      rd_index = 4'd9;
      #1 chk("nom_rd9", rd_data, 32'hA000_0009);
      @(negedge clock);
      chk("nom_done_once", fill_done, 0);
      chk("nom_idle", busy, 0);

      // Back-to-back grants; same-cycle read of the word being written sees old data
      start = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clock);
         start = 1'b0;
         chk("b2b_read", wb_if.WB_SRAM_read, 1);
         chk("b2b_addr", wb_if.WB_SRAM_address, 32'(i * 4));
         wb_if.WB_SRAM_ready    = 1'b1;
         wb_if.Weight_SRAM_data = 32'hB000_0000 + 32'(i);
         rd_index = 4'(i);
         #1 chk("b2b_rd_old", rd_data, 32'hA000_0000 + 32'(i));
      end
      @(negedge clock);
      wb_if.WB_SRAM_ready = 1'b0;
      chk("b2b_done", fill_done, 1);
      chk("b2b_read_done", wb_if.WB_SRAM_read, 0);
      rd_index = 4'd15;
      #1 chk("b2b_rd15_new", rd_data, 32'hB000_000F);
      rd_index = 4'd0;
      #1 chk("b2b_rd0", rd_data, 32'hB000_0000);

      // Flush in the same cycle as the sixth grant
      @(negedge clock);
      start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         start = 1'b0;
         chk("fl_addr", wb_if.WB_SRAM_address, 32'(i * 4));
         wb_if.WB_SRAM_ready    = 1'b1;
         wb_if.Weight_SRAM_data = 32'hC000_0000 + 32'(i);
      end
      @(negedge clock);
      chk("fl_addr5", wb_if.WB_SRAM_address, 32'd20);
      chk("fl_icv_before", ic_valid, 32'h03);
      wb_if.Weight_SRAM_data = 32'hC000_0005;
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      wb_if.WB_SRAM_ready = 1'b0;
      chk("fl_read", wb_if.WB_SRAM_read, 0);
      chk("fl_icv", ic_valid, 0);
      chk("fl_busy", busy, 0);
      chk("fl_addr_clr", wb_if.WB_SRAM_address, 0);
      rd_index = 4'd5;
      #1 chk("fl_rd5_unwritten", rd_data, 32'hB000_0005);
      rd_index = 4'd4;
      #1 chk("fl_rd4", rd_data, 32'hC000_0004);

      // Ready pulsed in IDLE is ignored
      @(negedge clock);
      wb_if.WB_SRAM_ready    = 1'b1;
      wb_if.Weight_SRAM_data = 32'hDEAD_BEEF;
      @(negedge clock);
      wb_if.WB_SRAM_ready = 1'b0;
      chk("sp_busy", busy, 0);
      chk("sp_addr", wb_if.WB_SRAM_address, 0);
      rd_index = 4'd0;
      #1 chk("sp_rd0", rd_data, 32'hC000_0000);

      // Restart after flush begins at address 0; start while busy is ignored
      start = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clock);
         start = 1'b0;
         chk("sp_addr_fill", wb_if.WB_SRAM_address, 32'(i * 4));
         wb_if.WB_SRAM_ready    = 1'b1;
         wb_if.Weight_SRAM_data = 32'hD000_0000 + 32'(i);
      end
      @(negedge clock);
      wb_if.WB_SRAM_ready = 1'b0;
      chk("sp_addr7", wb_if.WB_SRAM_address, 32'd28);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("sp_addr7_hold", wb_if.WB_SRAM_address, 32'd28);
      chk("sp_read_hold", wb_if.WB_SRAM_read, 1);
      wb_if.WB_SRAM_ready    = 1'b1;
      wb_if.Weight_SRAM_data = 32'hD000_0007;
      for (int i = 8; i < 16; i++) begin
         @(negedge clock);
         chk("sp_addr_rest", wb_if.WB_SRAM_address, 32'(i * 4));
         wb_if.Weight_SRAM_data = 32'hD000_0000 + 32'(i);
      end
      @(negedge clock);
      wb_if.WB_SRAM_ready = 1'b0;
      chk("sp_done", fill_done, 1);
      chk("sp_icv", ic_valid, 32'hFF);
      rd_index = 4'd7;
      #1 chk("sp_rd7", rd_data, 32'hD000_0007);
      rd_index = 4'd6;
      #1 chk("sp_rd6", rd_data, 32'hD000_0006);

      // Async reset between clock edges mid-fill
      @(negedge clock);
      start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         start = 1'b0;
         wb_if.WB_SRAM_ready    = 1'b1;
         wb_if.Weight_SRAM_data = 32'hE000_0000 + 32'(i);
      end
      @(negedge clock);
      wb_if.WB_SRAM_ready = 1'b0;
      chk("ar_icv_before", ic_valid, 32'h03);
      chk("ar_read_before", wb_if.WB_SRAM_read, 1);
      #2 reset = 1'b0;
      #1;
      chk("ar_read", wb_if.WB_SRAM_read, 0);
      chk("ar_busy", busy, 0);
      chk("ar_icv", ic_valid, 0);
      chk("ar_addr", wb_if.WB_SRAM_address, 0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      repeat (3) begin
         @(negedge clock);
         chk("ar_idle_busy", busy, 0);
         chk("ar_idle_read", wb_if.WB_SRAM_read, 0);
      end
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("ar_restart_read", wb_if.WB_SRAM_read, 1);
      chk("ar_restart_addr", wb_if.WB_SRAM_address, 0);
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      chk("ar_flush_read", wb_if.WB_SRAM_read, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
